// File: rtl/vga_timing_gen.sv
// Raster timing generator for the display path: pixel coordinates, visible flag,
// sync pulses and line/frame start strobes, stepping only on pix_en cycles.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       x_wrap;
    logic       y_wrap;
    logic       hs_next;
    logic       vs_next;
    logic       blank_next;

    // Flags are derived from the next coordinates so they line up with DrawX/DrawY.
    always_comb begin
        x_next = DrawX + 10'd1;
        y_next = DrawY;
        x_wrap = 1'b0;
        y_wrap = 1'b0;
        if (DrawX >= H_LAST) begin
            x_next = '0;
            x_wrap = 1'b1;
            if (DrawY >= V_LAST) begin
                y_next = '0;
                y_wrap = 1'b1;
            end else begin
                y_next = DrawY + 10'd1;
            end
        end
        blank_next = (x_next < H_VIS) && (y_next < V_VIS);
        hs_next    = ((x_next >= HS_START) && (x_next < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_next    = ((y_next >= VS_START) && (y_next < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b1;
            hs          <= ~SYNC_ACTIVE;
            vs          <= ~SYNC_ACTIVE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            blank       <= blank_next;
            hs          <= hs_next;
            vs          <= vs_next;
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
        end else begin
            // Strobes are one vga_clk wide regardless of the enable rate.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing and reset, shrunken
// instance (16x8 raster) for whole-frame, hold and wrap corner cases.
module tb_vga_timing_gen;

    logic       vga_clk = 1'b0;
    logic       reset, pix_en;
    logic [9:0] DrawX, DrawY;
    logic       hs, vs, blank, line_start, frame_start;

    logic       s_reset, s_pix_en;
    logic [9:0] s_x, s_y;
    logic       s_hs, s_vs, s_blank, s_ls, s_fs;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut (
        .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
        .DrawX(DrawX), .DrawY(DrawY), .hs(hs), .vs(vs), .blank(blank),
        .line_start(line_start), .frame_start(frame_start)
    );

    // Small raster: H 8+2+3+3=16 (hs low x=10..12), V 4+1+2+1=8 (vs low y=5..6)
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) dut_s (
        .vga_clk(vga_clk), .reset(s_reset), .pix_en(s_pix_en),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .line_start(s_ls), .frame_start(s_fs)
    );

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       b, h, v, ls, fs;
    } vec_t;

    vec_t tbl[12];
    int   vecs = 0;
    int   errs = 0;

    function automatic logic [24:0] pk(logic [9:0] x, logic [9:0] y,
                                       logic b, logic h, logic v, logic ls, logic fs);
        return {x, y, b, h, v, ls, fs};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    function automatic logic [24:0] big_now();
        return pk(DrawX, DrawY, blank, hs, vs, line_start, frame_start);
    endfunction

    function automatic logic [24:0] small_now();
        return pk(s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs);
    endfunction

    initial begin
        int n, hs_low, bad, fs_prev, ls_prev, ls_cnt, en_edges, vs_low, blank_cnt;
        int first_pulse, second_pulse;

        tbl[0]  = '{1,   10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{640, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{655, 10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{656, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{751, 10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{752, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{799, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{801, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1439, 10'd639, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1500, 10'd700, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; pix_en = 1'b1;
        s_reset = 1'b1; s_pix_en = 1'b1;
        repeat (3) tick();
        check("reset_hold", big_now(), pk(10'd0, 10'd0, 1, 1, 1, 0, 0));

        // Free run from reset release; enabled edge count n gives DrawX = n % 800.
        reset = 1'b0;
        n = 0; hs_low = 0;
        foreach (tbl[i]) begin
            while (n < tbl[i].n) begin
                tick();
                n++;
                if (n <= 799 && hs == 1'b0) hs_low++;
            end
            check($sformatf("vec%0d_n%0d", i, tbl[i].n), big_now(),
                  pk(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].h, tbl[i].v, tbl[i].ls, tbl[i].fs));
        end
        check("hs_low_width", hs_low, 96);

        // Mid-frame reset while hs is active.
        reset = 1'b1;
        tick();
        check("midframe_reset", big_now(), pk(10'd0, 10'd0, 1, 1, 1, 0, 0));
        reset = 1'b0;

        // Half-rate enable: DrawX tracks enabled edges, line_start stays 1 cycle wide.
        en_edges = 0; bad = 0; ls_cnt = 0; ls_prev = 0; first_pulse = -1; second_pulse = -1;
        for (int c = 0; c < 3300; c++) begin
            pix_en = (c % 2 == 0);
            if (pix_en) en_edges++;
            tick();
            if (DrawX != 10'(en_edges % 800)) bad++;
            if (line_start) begin
                if (ls_prev) bad++;
                ls_cnt++;
                if (first_pulse < 0) first_pulse = c;
                else if (second_pulse < 0) second_pulse = c;
            end
            ls_prev = line_start;
        end
        check("half_rate_track", bad, 0);
        check("half_rate_ls_count", ls_cnt, 2);
        check("half_rate_ls_period", second_pulse - first_pulse, 1600);
        pix_en = 1'b1;

        // Small raster: full frame statistics between frame_start pulses.
        s_reset = 1'b0;
        first_pulse = -1; second_pulse = -1; vs_low = 0; blank_cnt = 0; ls_cnt = 0;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (s_fs) begin
                if (first_pulse < 0) begin
                    first_pulse = c;
                    check("small_fs_coords", {s_x, s_y}, {10'd0, 10'd0});
                end else if (second_pulse < 0) second_pulse = c;
            end
            if (first_pulse > 0 && second_pulse < 0) begin
                if (!s_vs) vs_low++;
                if (s_blank) blank_cnt++;
                if (s_ls) ls_cnt++;
            end
        end
        check("small_first_fs", first_pulse, 128);
        check("small_frame_period", second_pulse - first_pulse, 128);
        check("small_vs_low", vs_low, 32);
        check("small_blank_cnt", blank_cnt, 32);
        check("small_ls_per_frame", ls_cnt, 8);

        // Park at the last pixel of the frame, then hold pix_en low.
        bad = 1;
        for (int c = 0; c < 200; c++) begin
            if (s_x == 10'd15 && s_y == 10'd7) begin
                bad = 0;
                break;
            end
            tick();
        end
        check("small_reach_last", bad, 0);
        s_pix_en = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (small_now() !== pk(10'd15, 10'd7, 0, 1, 1, 0, 0)) bad++;
        end
        check("small_hold_frozen", bad, 0);
        s_pix_en = 1'b1;
        tick();
        check("small_wrap_after_hold", small_now(), pk(10'd0, 10'd0, 1, 1, 1, 1, 1));
        s_pix_en = 1'b0;
        tick();
        check("small_pulse_one_cycle", small_now(), pk(10'd0, 10'd0, 1, 1, 1, 0, 0));

        // Small raster at half rate: frame period doubles, frame_start still 1 cycle.
        first_pulse = -1; second_pulse = -1; bad = 0; fs_prev = 0;
        for (int c = 0; c < 600; c++) begin
            s_pix_en = (c % 2 == 0);
            tick();
            if (s_fs) begin
                if (fs_prev) bad++;
                if (first_pulse < 0) first_pulse = c;
                else if (second_pulse < 0) second_pulse = c;
            end
            fs_prev = s_fs;
        end
        check("small_half_fs_width", bad, 0);
        check("small_half_first_fs", first_pulse, 254);
        check("small_half_period", second_pulse - first_pulse, 256);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
